// File: rtl/flush_recovery_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flush_recovery_ctrl_pkg
// Purpose  : Shared constants, state encodings and helpers for branch
//            misprediction recovery.
// Revision : 1.0
// ============================================================================
package flush_recovery_ctrl_pkg;

    localparam int c_NUM_PR   = 64;
    localparam int c_PR_WIDTH = 6;
    localparam int c_NUM_AR   = 32;

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_FLUSH    = 3'd1;
    localparam logic [2:0] c_ST_REBUILD  = 3'd2;
    localparam logic [2:0] c_ST_DRAIN    = 3'd3;
    localparam logic [2:0] c_ST_REDIRECT = 3'd4;

    // Retirement map layout shared with the RAT and RRF.
    typedef logic [c_NUM_AR-1:0][c_PR_WIDTH-1:0] rrf_map_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flush_recovery_ctrl_fl_rebuild_scanner.sv
`default_nettype none
// ============================================================================
// Module   : fl_rebuild_scanner
// Purpose  : Holds the mapped-register bitmap and walks every physical
//            register, returning the unmapped ones to the free list.
// Revision : 1.0
// ============================================================================
module fl_rebuild_scanner
    import flush_recovery_ctrl_pkg::*;
#(
    parameter int NUM_PR   = c_NUM_PR,
    parameter int PR_WIDTH = c_PR_WIDTH,
    parameter int NUM_AR   = c_NUM_AR
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_capture,
    input  logic [NUM_AR-1:0][PR_WIDTH-1:0] i_rrf_map,
    input  logic                            i_start,
    input  logic                            i_active,
    input  logic                            i_fl_full,
    output logic                            o_fl_enqueue,
    output logic [PR_WIDTH-1:0]             o_fl_wdata,
    output logic                            o_scan_done
);

    localparam logic [PR_WIDTH:0] c_IDX_LAST = (PR_WIDTH+1)'(NUM_PR - 1);
    localparam logic [PR_WIDTH:0] c_IDX_ONE  = (PR_WIDTH+1)'(1);

    logic [NUM_PR-1:0] r_mapped;
    logic [NUM_PR-1:0] w_mapped;
    logic [PR_WIDTH:0] r_scan_idx;
    logic              w_step;

    // Duplicate map entries simply collapse onto the same bit.
    always_comb begin
        w_mapped = '0;
        for (int i = 0; i < NUM_AR; i++) begin
            w_mapped[i_rrf_map[i]] = 1'b1;
        end
    end

    assign w_step       = i_active && !i_fl_full;
    assign o_fl_enqueue = w_step && !r_mapped[r_scan_idx[PR_WIDTH-1:0]];
    assign o_fl_wdata   = o_fl_enqueue ? r_scan_idx[PR_WIDTH-1:0] : '0;
    assign o_scan_done  = w_step && (r_scan_idx == c_IDX_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mapped   <= '0;
            r_scan_idx <= '0;
        end else begin
            if (i_capture) begin
                r_mapped <= w_mapped;
            end
            if (i_start) begin
                r_scan_idx <= '0;
            end else if (w_step) begin
                r_scan_idx <= r_scan_idx + c_IDX_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/flush_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : flush_recovery_ctrl
// Purpose  : Sequences recovery from a committed misprediction: flush, RAT
//            reload, free-list rebuild, memory drain and fetch redirect.
// Revision : 1.0
// ============================================================================
module flush_recovery_ctrl
    import flush_recovery_ctrl_pkg::*;
#(
    parameter int NUM_PR   = c_NUM_PR,
    parameter int PR_WIDTH = c_PR_WIDTH,
    parameter int NUM_AR   = c_NUM_AR
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush_req,
    input  logic [31:0]                     flush_pc,
    input  logic [63:0]                     flush_order,
    input  logic [NUM_AR-1:0][PR_WIDTH-1:0] rrf_map,
    input  logic                            mem_idle,
    input  logic                            fl_full,
    input  logic                            redirect_ready,
    output logic                            busy,
    output logic                            pipe_flush,
    output logic                            rat_load,
    output logic [NUM_AR-1:0][PR_WIDTH-1:0] rat_map,
    output logic                            fl_clear,
    output logic                            fl_enqueue,
    output logic [PR_WIDTH-1:0]             fl_wdata,
    output logic                            redirect_valid,
    output logic [31:0]                     redirect_pc,
    output logic [63:0]                     redirect_order,
    output logic [31:0]                     flush_count
);

    logic [2:0]                      r_state;
    logic [2:0]                      w_state_nxt;
    logic [NUM_AR-1:0][PR_WIDTH-1:0] r_rat_map;
    logic [31:0]                     r_pc;
    logic [63:0]                     r_order;
    logic [31:0]                     r_flush_count;
    logic                            w_capture;
    logic                            w_handshake;
    logic                            w_scan_done;

    assign w_capture   = (r_state == c_ST_IDLE) && flush_req;
    assign w_handshake = (r_state == c_ST_REDIRECT) && redirect_ready;

    // The drain check overlaps the final scan step, so an already idle
    // memory system costs no extra cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:     if (flush_req)      w_state_nxt = c_ST_FLUSH;
            c_ST_FLUSH:                        w_state_nxt = c_ST_REBUILD;
            c_ST_REBUILD:  if (w_scan_done)    w_state_nxt = mem_idle ? c_ST_REDIRECT : c_ST_DRAIN;
            c_ST_DRAIN:    if (mem_idle)       w_state_nxt = c_ST_REDIRECT;
            c_ST_REDIRECT: if (redirect_ready) w_state_nxt = c_ST_IDLE;
            default:                           w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= c_ST_IDLE;
            r_rat_map     <= '0;
            r_pc          <= '0;
            r_order       <= '0;
            r_flush_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_rat_map <= rrf_map;
                r_pc      <= flush_pc;
                r_order   <= flush_order + 64'd1;
            end
            if (w_handshake) begin
                r_flush_count <= sat_inc32(r_flush_count);
            end
        end
    end

    fl_rebuild_scanner #(
        .NUM_PR   (NUM_PR),
        .PR_WIDTH (PR_WIDTH),
        .NUM_AR   (NUM_AR)
    ) u_scanner (
        .clk          (clk),
        .rst          (rst),
        .i_capture    (w_capture),
        .i_rrf_map    (rrf_map),
        .i_start      (r_state == c_ST_FLUSH),
        .i_active     (r_state == c_ST_REBUILD),
        .i_fl_full    (fl_full),
        .o_fl_enqueue (fl_enqueue),
        .o_fl_wdata   (fl_wdata),
        .o_scan_done  (w_scan_done)
    );

    assign busy           = (r_state != c_ST_IDLE);
    assign pipe_flush     = (r_state == c_ST_FLUSH);
    assign rat_load       = (r_state == c_ST_FLUSH);
    assign fl_clear       = (r_state == c_ST_FLUSH);
    assign redirect_valid = (r_state == c_ST_REDIRECT);
    assign rat_map        = r_rat_map;
    assign redirect_pc    = r_pc;
    assign redirect_order = r_order;
    assign flush_count    = r_flush_count;

endmodule
`default_nettype wire
